vram_arbiter: RTL and testbench



---
 rtl/video_pkg.sv | 20 ++
 rtl/vram_arbiter.sv | 120 ++++++++++++
 tb/tb_vram_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// video_pkg
// Shared constants and types for the video subsystem: VRAM geometry, the
// data width, the VRAM layout used by the scanline fetcher, and the
// arbiter state encoding.
package video_pkg;

  localparam int RAM_SIZE       = 8192;
  localparam int RAM_ADDR_WIDTH = $clog2(RAM_SIZE);
  localparam int XLEN           = 8;

  // Where the fetcher finds the pixel rows, and the spacing between rows.
  localparam logic [RAM_ADDR_WIDTH-1:0] VRAM_BASE  = RAM_ADDR_WIDTH'('h400);
  localparam logic [RAM_ADDR_WIDTH-1:0] ROW_STRIDE = RAM_ADDR_WIDTH'('h20);

  typedef enum logic [0:0] {
    ARB_IDLE     = 1'b0,
    ARB_CPU_DONE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Shares one single-port synchronous VRAM (1-cycle read latency) between the
// scanline fetcher and the CPU. Video always wins and returns data exactly
// one cycle after its strobe. The CPU is served in free cycles with a
// req/ack handshake. A sticky flag records excessive CPU waiting.
//
// Ports
//   clk, rst                    clock, async active-high reset
//   vid_req/vid_addr            fetch strobe and address
//   vid_data/vid_valid          fetched byte, valid one cycle after vid_req
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata                   CPU request, held until cpu_ack
//   cpu_rdata/cpu_ack           CPU read data and completion pulse
//   cpu_starved                 sticky starvation flag
//   ram_addr/ram_we/ram_wdata   RAM command (combinational)
//   ram_rdata                   RAM read data
//
// state        | meaning
// ARB_IDLE     | free to grant video or CPU
// ARB_CPU_DONE | CPU access issued last cycle; ack it, video may still fetch
module vram_arbiter
  import video_pkg::*;
#(
  parameter int RAM_SIZE       = video_pkg::RAM_SIZE,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int XLEN           = video_pkg::XLEN,
  parameter int STARVE_LIMIT   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vid_req,
  input  logic [RAM_ADDR_WIDTH-1:0] vid_addr,
  output logic [XLEN-1:0]           vid_data,
  output logic                      vid_valid,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [RAM_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [XLEN-1:0]           cpu_wdata,
  output logic [XLEN-1:0]           cpu_rdata,
  output logic                      cpu_ack,
  output logic                      cpu_starved,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_we,
  output logic [XLEN-1:0]           ram_wdata,
  input  logic [XLEN-1:0]           ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic             cpu_grant;
  logic             cpu_wait;
  logic             rd_pending;
  logic [XLEN-1:0]  rdata_hold;
  logic [CNT_W-1:0] wait_cnt;

  // Gating with rst keeps a write from reaching the RAM while in reset and
  // drops any CPU access that would otherwise be granted during reset.
  assign cpu_grant = !rst && (state == ARB_IDLE) && cpu_req && !vid_req;
  assign cpu_wait  = (state == ARB_IDLE) && cpu_req && vid_req;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (vid_req) begin
      ram_addr = vid_addr;
    end else if (cpu_grant) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      rd_pending <= 1'b0;
      vid_valid  <= 1'b0;
    end else begin
      state      <= cpu_grant ? ARB_CPU_DONE : ARB_IDLE;
      rd_pending <= cpu_grant && !cpu_we;
      vid_valid  <= vid_req;
    end
  end

  assign cpu_ack = (state == ARB_CPU_DONE);

  // The RAM output register supplies the data in the return cycle; the hold
  // register keeps the last CPU read byte visible afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hold <= '0;
    end else if (cpu_ack && rd_pending) begin
      rdata_hold <= ram_rdata;
    end
  end

  assign cpu_rdata = (cpu_ack && rd_pending) ? ram_rdata : rdata_hold;
  assign vid_data  = vid_valid ? ram_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      cpu_starved <= 1'b0;
    end else begin
      if (cpu_grant) begin
        wait_cnt <= '0;
      end else if (cpu_wait && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // Set on the same edge the counter reaches the limit.
      if (cpu_wait && (wait_cnt == CNT_MAX - CNT_W'(1))) begin
        cpu_starved <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural synchronous RAM
// (read-before-write, 1-cycle latency) preloaded with mem[a] = a[7:0] ^ 8'h5A.
module tb_vram_arbiter;
  import video_pkg::*;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic          cpu_starved;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic [7:0] mem [0:8191];

  int errors = 0;
  int checks = 0;

  vram_arbiter #(
    .RAM_SIZE(8192), .XLEN(8), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_starved(cpu_starved),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = pat(i);
    rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    chk("rst_vid_valid", 32'(vid_valid), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = VRAM_BASE;
    #1 chk("pre_rst_grant_addr", 32'(ram_addr), 32'h400);
    rst = 1'b1;
    #1 chk("rst_no_grant_addr", 32'(ram_addr), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    tick();
    chk("rst_mid_ack", 32'(cpu_ack), 0);
    chk("rst_mid_rdata", 32'(cpu_rdata), 0);
    chk("rst_mid_vid_data", 32'(vid_data), 0);
    chk("rst_mid_starved", 32'(cpu_starved), 0);
    rst = 1'b0;
    #1 chk("post_rst_grant", 32'(ram_addr), 32'h400);
    tick();
    chk("post_rst_ack", 32'(cpu_ack), 1);
    chk("post_rst_rdata", 32'(cpu_rdata), 32'h5A);
    cpu_req = 1'b0;
    tick();
    chk("post_rst_ack_clear", 32'(cpu_ack), 0);

    // Write 'hA5 to 'h1234 then read it back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1234; cpu_wdata = 8'hA5;
    #1 chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_addr", 32'(ram_addr), 32'h1234);
    chk("wr_ram_wdata", 32'(ram_wdata), 32'hA5);
    tick();
    chk("wr_ack", 32'(cpu_ack), 1);
    chk("wr_rdata_unchanged", 32'(cpu_rdata), 32'h5A);
    cpu_we = 1'b0;
    #1 chk("ack_cycle_ignores_req", 32'(ram_addr), 0);
    tick();
    chk("rd_grant_addr", 32'(ram_addr), 32'h1234);
    chk("rd_grant_no_ack", 32'(cpu_ack), 0);
    tick();
    chk("rd_ack", 32'(cpu_ack), 1);
    chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
    cpu_req = 1'b0;
    tick();
    chk("rd_rdata_held", 32'(cpu_rdata), 32'hA5);

    // Collision: video wins, CPU follows
    vid_req = 1'b1; vid_addr = 13'h420;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h430;
    #1 chk("col_ram_addr", 32'(ram_addr), 32'h420);
    chk("col_ram_we", 32'(ram_we), 0);
    tick();
    vid_req = 1'b0;
    chk("col_vid_valid", 32'(vid_valid), 1);
    chk("col_vid_data", 32'(vid_data), 32'(pat('h420)));
    chk("col_no_ack", 32'(cpu_ack), 0);
    #1 chk("col_cpu_grant", 32'(ram_addr), 32'h430);
    tick();
    chk("col_cpu_ack", 32'(cpu_ack), 1);
    chk("col_cpu_rdata", 32'(cpu_rdata), 32'(pat('h430)));
    chk("col_vid_valid_clear", 32'(vid_valid), 0);
    cpu_req = 1'b0;
    tick();

    // Video fetch in the CPU ack cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h440;
    tick();
    cpu_req = 1'b0;
    vid_req = 1'b1; vid_addr = 13'h441;
    #1 chk("vdone_ram_addr", 32'(ram_addr), 32'h441);
    chk("vdone_ack", 32'(cpu_ack), 1);
    chk("vdone_rdata", 32'(cpu_rdata), 32'(pat('h440)));
    tick();
    vid_req = 1'b0;
    chk("vdone_vid_valid", 32'(vid_valid), 1);
    chk("vdone_vid_data", 32'(vid_data), 32'(pat('h441)));
    chk("vdone_rdata_kept", 32'(cpu_rdata), 32'(pat('h440)));
    chk("vdone_ack_clear", 32'(cpu_ack), 0);
    tick();

    // Video every 2 cycles with a CPU read pending
    for (int i = 0; i < 3; i++) begin
      vid_req = 1'b1; vid_addr = 13'(13'h500 + 2 * i);
      if (i == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h510;
      end
      tick();
      vid_req = 1'b0;
      chk("str_vid_valid", 32'(vid_valid), 1);
      chk("str_vid_data", 32'(vid_data), 32'(pat('h500 + 2 * i)));
      chk("str_no_ack_in_gap", 32'(cpu_ack), 0);
      tick();
      chk("str_vid_valid_low", 32'(vid_valid), 0);
      chk("str_cpu_ack", 32'(cpu_ack), (i == 0) ? 32'd1 : 32'd0);
      if (i == 0) begin
        chk("str_cpu_rdata", 32'(cpu_rdata), 32'(pat('h510)));
        cpu_req = 1'b0;
      end
    end
    tick();

    // Starvation with the fetcher strobing every cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h600;
    for (int k = 0; k < 4; k++) begin
      vid_req = 1'b1; vid_addr = 13'(13'h700 + k);
      #1 chk("stv_not_yet", 32'(cpu_starved), 0);
      tick();
      chk("stv_vid_data", 32'(vid_data), 32'(pat('h700 + k)));
    end
    chk("stv_set", 32'(cpu_starved), 1);
    vid_req = 1'b0;
    #1 chk("stv_cpu_grant", 32'(ram_addr), 32'h600);
    tick();
    chk("stv_ack", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    tick(); tick();
    chk("stv_sticky", 32'(cpu_starved), 1);
    rst = 1'b1;
    #1 chk("stv_cleared_by_rst", 32'(cpu_starved), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
